snake_frame_scheduler: RTL

Game-logic sequencer for the snake datapath. Once per video frame it advances the snake every FRAMES_PER_STEP frames: new head, body shift, growth on fruit, self-collision. It then streams the body register file to the renderer through `body_count`/`snake_body_x`/`snake_body_y`. All work runs in vertical blanking, triggered by the rising edge of `frame_tik`.

---
 rtl/snake_frame_scheduler_if.sv | 40 ++++
 rtl/snake_frame_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/snake_frame_scheduler_if.sv
// +----------------------------------------------------------------------------+
// | snake_frame_scheduler_if                                                    |
// | Control, fruit and render-stream signals of the snake frame scheduler.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface snake_frame_scheduler_if #(
  parameter int SNAKE_LENGTH_BIT = 4
);
  logic                        frame_tik;
  logic                        game_run;
  logic                        restart;
  logic [1:0]                  direction;
  logic [6:0]                  fruit_x;
  logic [6:0]                  fruit_y;
  logic [6:0]                  snake_head_x;
  logic [6:0]                  snake_head_y;
  logic [SNAKE_LENGTH_BIT-1:0] snake_length;
  logic [SNAKE_LENGTH_BIT-1:0] body_count;
  logic [6:0]                  snake_body_x;
  logic [6:0]                  snake_body_y;
  logic                        fruit_eaten;
  logic                        game_over;
  logic                        busy;

  modport master (
    output frame_tik, game_run, restart, direction, fruit_x, fruit_y,
    input  snake_head_x, snake_head_y, snake_length, body_count,
           snake_body_x, snake_body_y, fruit_eaten, game_over, busy
  );

  modport slave (
    input  frame_tik, game_run, restart, direction, fruit_x, fruit_y,
    output snake_head_x, snake_head_y, snake_length, body_count,
           snake_body_x, snake_body_y, fruit_eaten, game_over, busy
  );
endinterface

`default_nettype wire

// File: rtl/snake_frame_scheduler.sv
// +----------------------------------------------------------------------------+
// | snake_frame_scheduler                                                       |
// | Per-frame snake step (move/shift/grow/collide) and body stream to renderer. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module snake_frame_scheduler #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 2**SNAKE_LENGTH_BIT,
  parameter int GRID_W           = 124,
  parameter int GRID_H           = 81,
  parameter int FRAMES_PER_STEP  = 8,
  parameter int INIT_LENGTH      = 3
) (
  input  wire logic clock_25,
  input  wire logic reset,
  snake_frame_scheduler_if.slave bus
);

  localparam int c_fc_w = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  localparam logic [6:0]                  c_x_last    = 7'(GRID_W - 1);
  localparam logic [6:0]                  c_y_last    = 7'(GRID_H - 1);
  localparam logic [6:0]                  c_init_x    = 7'd62;
  localparam logic [6:0]                  c_init_y    = 7'd40;
  localparam logic [SNAKE_LENGTH_BIT-1:0] c_len_init  = SNAKE_LENGTH_BIT'(INIT_LENGTH);
  localparam logic [SNAKE_LENGTH_BIT-1:0] c_idx_last  = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
  localparam logic [c_fc_w-1:0]           c_fc_last   = c_fc_w'(FRAMES_PER_STEP - 1);

  localparam logic [1:0] c_dir_up    = 2'b00;
  localparam logic [1:0] c_dir_down  = 2'b01;
  localparam logic [1:0] c_dir_left  = 2'b10;
  localparam logic [1:0] c_dir_right = 2'b11;

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_move   = 3'd1;
  localparam logic [2:0] c_st_shift  = 3'd2;
  localparam logic [2:0] c_st_check  = 3'd3;
  localparam logic [2:0] c_st_stream = 3'd4;

  logic [2:0]                  r_state, w_state_next;
  logic                        r_tik_q, r_tik_qq;
  logic [6:0]                  r_head_x, r_head_y, r_next_x, r_next_y;
  logic [1:0]                  r_cur_dir;
  logic [6:0]                  r_body_x [SNAKE_LENGTH_MAX];
  logic [6:0]                  r_body_y [SNAKE_LENGTH_MAX];
  logic [SNAKE_LENGTH_BIT-1:0] r_length, r_idx, r_body_count;
  logic [c_fc_w-1:0]           r_frame_cnt;
  logic                        r_grow, r_hit, r_game_over, r_fruit_eaten;
  logic [6:0]                  r_snake_body_x, r_snake_body_y;

  logic                        w_tik_edge, w_step_due, w_reversal;
  logic [1:0]                  w_dir;
  logic [6:0]                  w_next_x, w_next_y;
  logic                        w_fruit_hit, w_grow, w_self_hit;
  logic                        w_check_last, w_stream_last;
  logic [SNAKE_LENGTH_BIT-1:0] w_count_next;
  logic                        w_busy, w_init, w_frame_adv, w_latch_move;
  logic                        w_shift_en, w_check_en, w_stream_en, w_stream_load;

  assign w_tik_edge    = r_tik_q & ~r_tik_qq;
  assign w_step_due    = bus.game_run & ~r_game_over & (r_frame_cnt == c_fc_last);
  // Same axis, other sense: a 180-degree turn is refused
  assign w_reversal    = (bus.direction[1] == r_cur_dir[1]) && (bus.direction[0] != r_cur_dir[0]);
  assign w_dir         = w_reversal ? r_cur_dir : bus.direction;
  assign w_fruit_hit   = (w_next_x == bus.fruit_x) && (w_next_y == bus.fruit_y);
  assign w_grow        = w_fruit_hit && (r_length < c_idx_last);
  assign w_self_hit    = (r_head_x == r_body_x[r_idx]) && (r_head_y == r_body_y[r_idx]);
  assign w_check_last  = (r_idx == r_length - 1'b1);
  assign w_stream_last = (r_body_count == c_idx_last);
  assign w_count_next  = (r_state == c_st_stream) ? r_body_count + 1'b1 : '0;

  always_comb begin
    w_next_x = r_head_x;
    w_next_y = r_head_y;
    case (w_dir)
      c_dir_up:    w_next_y = (r_head_y == 7'd0)     ? c_y_last : r_head_y - 1'b1;
      c_dir_down:  w_next_y = (r_head_y == c_y_last) ? 7'd0     : r_head_y + 1'b1;
      c_dir_left:  w_next_x = (r_head_x == 7'd0)     ? c_x_last : r_head_x - 1'b1;
      c_dir_right: w_next_x = (r_head_x == c_x_last) ? 7'd0     : r_head_x + 1'b1;
      default:     w_next_x = r_head_x;
    endcase
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:   if (!bus.restart && w_tik_edge)
                     w_state_next = w_step_due ? c_st_move : c_st_stream;
      c_st_move:   w_state_next = c_st_shift;
      c_st_shift:  if (r_idx == '0) w_state_next = c_st_check;
      c_st_check:  if (w_check_last) w_state_next = c_st_stream;
      c_st_stream: if (w_stream_last) w_state_next = c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_busy        = (r_state != c_st_idle);
    w_init        = (r_state == c_st_idle) && bus.restart;
    w_frame_adv   = (r_state == c_st_idle) && !bus.restart && w_tik_edge
                    && bus.game_run && !r_game_over;
    w_latch_move  = (r_state == c_st_move);
    w_shift_en    = (r_state == c_st_shift);
    w_check_en    = (r_state == c_st_check);
    w_stream_en   = (r_state == c_st_stream);
    w_stream_load = (w_state_next == c_st_stream);
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_tik_q        <= 1'b0;
      r_tik_qq       <= 1'b0;
      r_head_x       <= c_init_x;
      r_head_y       <= c_init_y;
      r_next_x       <= c_init_x;
      r_next_y       <= c_init_y;
      r_cur_dir      <= c_dir_right;
      r_length       <= c_len_init;
      r_idx          <= '0;
      r_body_count   <= '0;
      r_frame_cnt    <= '0;
      r_grow         <= 1'b0;
      r_hit          <= 1'b0;
      r_game_over    <= 1'b0;
      r_fruit_eaten  <= 1'b0;
      r_snake_body_x <= 7'd0;
      r_snake_body_y <= 7'd0;
      for (int k = 0; k < SNAKE_LENGTH_MAX; k++) begin
        r_body_x[k] <= (k < INIT_LENGTH) ? c_init_x - 7'(k + 1) : 7'd0;
        r_body_y[k] <= (k < INIT_LENGTH) ? c_init_y : 7'd0;
      end
    end else begin
      r_tik_q       <= bus.frame_tik;
      r_tik_qq      <= r_tik_q;
      r_fruit_eaten <= 1'b0;

      if (w_init) begin
        r_head_x    <= c_init_x;
        r_head_y    <= c_init_y;
        r_cur_dir   <= c_dir_right;
        r_length    <= c_len_init;
        r_frame_cnt <= '0;
        r_game_over <= 1'b0;
        for (int k = 0; k < SNAKE_LENGTH_MAX; k++) begin
          r_body_x[k] <= (k < INIT_LENGTH) ? c_init_x - 7'(k + 1) : 7'd0;
          r_body_y[k] <= (k < INIT_LENGTH) ? c_init_y : 7'd0;
        end
      end else if (w_frame_adv) begin
        r_frame_cnt <= (r_frame_cnt == c_fc_last) ? '0 : r_frame_cnt + 1'b1;
      end

      // Growing keeps the tail: the shift then starts one slot further out
      if (w_latch_move) begin
        r_cur_dir <= w_dir;
        r_next_x  <= w_next_x;
        r_next_y  <= w_next_y;
        r_grow    <= w_grow;
        r_hit     <= w_fruit_hit;
        r_idx     <= w_grow ? r_length : r_length - 1'b1;
      end

      if (w_shift_en) begin
        if (r_idx != '0) begin
          r_body_x[r_idx] <= r_body_x[r_idx - 1'b1];
          r_body_y[r_idx] <= r_body_y[r_idx - 1'b1];
          r_idx           <= r_idx - 1'b1;
        end else begin
          r_body_x[0]   <= r_head_x;
          r_body_y[0]   <= r_head_y;
          r_head_x      <= r_next_x;
          r_head_y      <= r_next_y;
          r_length      <= r_length + {{(SNAKE_LENGTH_BIT-1){1'b0}}, r_grow};
          r_fruit_eaten <= r_hit;
        end
      end

      if (w_check_en) begin
        if (w_self_hit) r_game_over <= 1'b1;
        r_idx <= r_idx + 1'b1;
      end

      if (w_stream_en)
        r_body_count <= w_stream_last ? '0 : r_body_count + 1'b1;

      // Keeps snake_body_* aligned with body_count while streaming
      if (w_stream_load) begin
        r_snake_body_x <= r_body_x[w_count_next];
        r_snake_body_y <= r_body_y[w_count_next];
      end
    end
  end

  assign bus.snake_head_x = r_head_x;
  assign bus.snake_head_y = r_head_y;
  assign bus.snake_length = r_length;
  assign bus.body_count   = r_body_count;
  assign bus.snake_body_x = r_snake_body_x;
  assign bus.snake_body_y = r_snake_body_y;
  assign bus.fruit_eaten  = r_fruit_eaten;
  assign bus.game_over    = r_game_over;
  assign bus.busy         = w_busy;

endmodule

`default_nettype wire
